// File: rtl/power_pkg.sv
// Shared types and helpers for the lane power sequencer: FSM state encoding,
// default always-on lane set and a lowest-set-bit picker.
package power_pkg;

  localparam int         NUM_LANES_DEF = 5;
  localparam logic [4:0] ALWAYS_ON_DEF = 5'b00111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SELECT,
    S_ISO_ON,
    S_PWR_OFF,
    S_PWR_ON,
    S_WAIT_ACK,
    S_SETTLE,
    S_ISO_OFF,
    S_DONE
  } seqState_t;

  // Keeps only the lowest set bit, so the chosen lane comes back one-hot.
  function automatic logic [31:0] lowestSetBit(input logic [31:0] vec);
    return vec & (~vec + 32'd1);
  endfunction

endpackage

// File: rtl/lane_power_sequencer_if.sv
// Request/power-gate bundle between reconfiguration control, the lane power
// gates and the sequencer.
interface lane_power_sequencer_if #(
  parameter int NUM_LANES = 5
);
  logic [NUM_LANES-1:0] targetMask_i;
  logic                 loadNewConfig_i;
  logic [NUM_LANES-1:0] powerGood_i;
  logic [NUM_LANES-1:0] powerEn_o;
  logic [NUM_LANES-1:0] isolate_o;
  logic [NUM_LANES-1:0] laneActive_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 error_o;

  modport master (
    output targetMask_i, loadNewConfig_i, powerGood_i,
    input  powerEn_o, isolate_o, laneActive_o, busy_o, done_o, error_o
  );

  modport slave (
    input  targetMask_i, loadNewConfig_i, powerGood_i,
    output powerEn_o, isolate_o, laneActive_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/lane_sync2.sv
// Two-flop synchroniser for one asynchronous power-good bit.
module lane_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic asyncIn,
  output logic syncOut
);
  logic meta;

  // NOTE: flops use non-blocking assignments so meta and syncOut shift together on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta    <= 1'b0;
      syncOut <= 1'b0;
    end else begin
      meta    <= asyncIn;
      syncOut <= meta;
    end
  end
endmodule

// File: rtl/lane_power_sequencer.sv
// Services lane power-downs then power-ups one lane at a time, with isolation
// and settle timing around each header switch change.
module lane_power_sequencer
  import power_pkg::*;
#(
  parameter int                   NUM_LANES   = NUM_LANES_DEF,
  parameter logic [NUM_LANES-1:0] ALWAYS_ON   = NUM_LANES'(ALWAYS_ON_DEF),
  parameter int                   SLEEP_DLY   = 2,
  parameter int                   WAKE_DLY    = 4,
  parameter int                   ACK_TIMEOUT = 15,
  parameter int                   CNT_W       = 4
) (
  input logic                   clk,
  input logic                   reset,
  lane_power_sequencer_if.slave bus
);

  seqState_t            state, stateNext;
  logic [NUM_LANES-1:0] lane, laneNext;
  logic [CNT_W-1:0]     cnt, cntNext, cntInc;
  logic [NUM_LANES-1:0] target, targetNext;
  logic [NUM_LANES-1:0] pendTarget, pendTargetNext;
  logic                 pendValid, pendValidNext;
  logic [NUM_LANES-1:0] failed, failedNext;
  logic [NUM_LANES-1:0] powerEn, powerEnNext;
  logic [NUM_LANES-1:0] isolate, isolateNext;
  logic [NUM_LANES-1:0] laneActive, laneActiveNext;
  logic                 error, errorNext;
  logic [NUM_LANES-1:0] pgSync, loadTarget, offMask, onMask;

  for (genvar g = 0; g < NUM_LANES; g++) begin : gSync
    lane_sync2 uSync (
      .clk    (clk),
      .reset  (reset),
      .asyncIn(bus.powerGood_i[g]),
      .syncOut(pgSync[g])
    );
  end

  assign loadTarget = bus.targetMask_i | ALWAYS_ON;
  assign offMask    = laneActive & ~target;
  // Lanes that timed out in this request are skipped until a new target arrives.
  assign onMask     = ~laneActive & target & ~failed;
  assign cntInc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  always_comb begin
    // NOTE: every next value defaults to its current value first, so no path through the case infers a latch.
    stateNext      = state;
    laneNext       = lane;
    cntNext        = cnt;
    targetNext     = target;
    pendTargetNext = pendTarget;
    pendValidNext  = pendValid;
    failedNext     = failed;
    powerEnNext    = powerEn;
    isolateNext    = isolate;
    laneActiveNext = laneActive;
    errorNext      = error;

    if (bus.loadNewConfig_i) begin
      errorNext = 1'b0;
      if (state != S_IDLE && state != S_DONE) begin
        pendTargetNext = loadTarget;
        pendValidNext  = 1'b1;
      end
    end

    unique case (state)
      S_IDLE: begin
        if (bus.loadNewConfig_i) begin
          targetNext = loadTarget;
          failedNext = '0;
          stateNext  = S_SELECT;
        end
      end
      S_SELECT: begin
        cntNext = '0;
        if (|offMask) begin
          laneNext       = NUM_LANES'(lowestSetBit(32'(offMask)));
          isolateNext    = isolate | laneNext;
          laneActiveNext = laneActive & ~laneNext;
          stateNext      = S_ISO_ON;
        end else if (|onMask) begin
          laneNext    = NUM_LANES'(lowestSetBit(32'(onMask)));
          powerEnNext = powerEn | laneNext;
          stateNext   = S_PWR_ON;
        end else begin
          stateNext = S_DONE;
        end
      end
      S_ISO_ON: begin
        if (cnt == CNT_W'(SLEEP_DLY - 1)) begin
          powerEnNext = powerEn & ~lane;
          stateNext   = S_PWR_OFF;
        end else begin
          cntNext = cntInc;
        end
      end
      S_PWR_OFF: stateNext = S_SELECT;
      S_PWR_ON: begin
        cntNext   = '0;
        stateNext = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (|(pgSync & lane)) begin
          cntNext   = '0;
          stateNext = S_SETTLE;
        end else if (cnt == CNT_W'(ACK_TIMEOUT)) begin
          errorNext   = 1'b1;
          powerEnNext = powerEn & ~lane;
          failedNext  = failed | lane;
          stateNext   = S_SELECT;
        end else begin
          cntNext = cntInc;
        end
      end
      S_SETTLE: begin
        if (cnt == CNT_W'(WAKE_DLY - 1)) begin
          isolateNext    = isolate & ~lane;
          laneActiveNext = laneActive | lane;
          stateNext      = S_ISO_OFF;
        end else begin
          cntNext = cntInc;
        end
      end
      S_ISO_OFF: stateNext = S_SELECT;
      S_DONE: begin
        // A load landing in DONE is taken directly so it cannot strand in pending.
        if (bus.loadNewConfig_i) begin
          targetNext    = loadTarget;
          pendValidNext = 1'b0;
          failedNext    = '0;
          stateNext     = S_SELECT;
        end else if (pendValid) begin
          targetNext    = pendTarget;
          pendValidNext = 1'b0;
          failedNext    = '0;
          stateNext     = S_SELECT;
        end else begin
          stateNext = S_IDLE;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      lane       <= '0;
      cnt        <= '0;
      target     <= '1;
      pendTarget <= '0;
      pendValid  <= 1'b0;
      failed     <= '0;
      powerEn    <= '1;
      isolate    <= '0;
      laneActive <= '1;
      error      <= 1'b0;
    end else begin
      state      <= stateNext;
      lane       <= laneNext;
      cnt        <= cntNext;
      target     <= targetNext;
      pendTarget <= pendTargetNext;
      pendValid  <= pendValidNext;
      failed     <= failedNext;
      powerEn    <= powerEnNext;
      isolate    <= isolateNext;
      laneActive <= laneActiveNext;
      error      <= errorNext;
    end
  end

  assign bus.powerEn_o    = powerEn;
  assign bus.isolate_o    = isolate;
  assign bus.laneActive_o = laneActive;
  assign bus.busy_o       = (state != S_IDLE);
  assign bus.done_o       = (state == S_DONE);
  assign bus.error_o      = error;

endmodule

// File: tb/tb_lane_power_sequencer.sv
// Self-checking bench: a power-gate model with per-lane ack delay, directed
// scenarios and randomized requests against a mask-level reference model.
module tb_lane_power_sequencer;

  localparam logic [4:0] AO          = 5'b00111;
  localparam int         SLEEP_DLY   = 2;
  localparam int         WAKE_DLY    = 4;
  localparam int         ACK_TIMEOUT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lane_power_sequencer_if #(.NUM_LANES(5)) bus ();

  lane_power_sequencer #(
    .NUM_LANES(5), .ALWAYS_ON(AO), .SLEEP_DLY(SLEEP_DLY), .WAKE_DLY(WAKE_DLY),
    .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         loadCyc;
  logic [4:0] prevEn  = '1;
  logic [4:0] prevIso = '0;
  logic       prevErr = 1'b0;
  logic [4:0] pg      = '1;
  logic [4:0] dead    = '0;
  bit         monOn   = 1'b0;
  int         ackDly  = 3;
  int         onCnt   [5];
  int         riseIso [5];
  int         fallIso [5];
  int         riseEn  [5];
  int         fallEn  [5];
  int         pgRise  [5];
  int         doneCnt, lastDone, errRise;
  logic [4:0] firstDoneAct, touched, modelActive;
  int         touchQ[$];

  task automatic clear_rec();
    for (int i = 0; i < 5; i++) begin
      riseIso[i] = -1; fallIso[i] = -1; riseEn[i] = -1; fallEn[i] = -1; pgRise[i] = -1;
    end
    doneCnt = 0; lastDone = -1; errRise = -1; firstDoneAct = '0;
    touched = '0; touchQ.delete();
  endtask

  // One clock: sample at the falling edge, run invariants, record edges, update gate model.
  task automatic step();
    logic [4:0] en, iso, act, chg;
    @(negedge clk);
    cyc++;
    en = bus.powerEn_o; iso = bus.isolate_o; act = bus.laneActive_o;
    if (monOn) begin
      chg = (en ^ prevEn) | (iso ^ prevIso);
      total++;
      if ($countones(chg) > 1) begin
        bad++; $display("FAIL one_lane_per_cycle cyc=%0d: changed=%b want at most one lane", cyc, chg);
      end
      total++;
      if ((en & AO) !== AO || (iso & AO) !== 5'b0) begin
        bad++; $display("FAIL always_on_untouched cyc=%0d: en=%b iso=%b want en/iso of %b on/clear", cyc, en, iso, AO);
      end
      total++;
      if ((act & ~(en & ~iso)) !== 5'b0) begin
        bad++; $display("FAIL active_implies_powered cyc=%0d: active=%b en=%b iso=%b", cyc, act, en, iso);
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (iso[i] && !prevIso[i]) riseIso[i] = cyc;
      if (!iso[i] && prevIso[i]) fallIso[i] = cyc;
      if (en[i] && !prevEn[i]) riseEn[i] = cyc;
      if (!en[i] && prevEn[i]) fallEn[i] = cyc;
      if (((iso[i] && !prevIso[i]) || (en[i] && !prevEn[i])) && !touched[i]) begin
        touched[i] = 1'b1; touchQ.push_back(i);
      end
    end
    if (bus.done_o === 1'b1) begin
      if (doneCnt == 0) firstDoneAct = act;
      doneCnt++; lastDone = cyc;
    end
    if (bus.error_o === 1'b1 && !prevErr) errRise = cyc;
    prevEn = en; prevIso = iso; prevErr = bus.error_o;
    // Gate cell: power-good follows the header enable after ackDly cycles unless the lane is dead.
    for (int i = 0; i < 5; i++) begin
      if (!en[i]) begin
        onCnt[i] = 0; pg[i] = 1'b0;
      end else if (!dead[i]) begin
        onCnt[i]++;
        if (onCnt[i] > ackDly && !pg[i]) begin pg[i] = 1'b1; pgRise[i] = cyc; end
      end
    end
    bus.powerGood_i = pg;
  endtask

  task automatic load(input logic [4:0] m);
    bus.targetMask_i = m; bus.loadNewConfig_i = 1'b1;
    step();
    bus.loadNewConfig_i = 1'b0;
    loadCyc = cyc;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (bus.busy_o === 1'b1 && n < budget) begin step(); n++; end
    total++;
    if (bus.busy_o !== 1'b0) begin
      bad++; $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", name, bus.busy_o, budget);
    end
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (bus.powerEn_o !== 5'b11111) begin bad++; $display("FAIL reset_en: got %b want 11111", bus.powerEn_o); end
    total++; if (bus.laneActive_o !== 5'b11111) begin bad++; $display("FAIL reset_active: got %b want 11111", bus.laneActive_o); end
    total++; if (bus.isolate_o !== 5'b00000) begin bad++; $display("FAIL reset_iso: got %b want 00000", bus.isolate_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    total++; if (bus.error_o !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", bus.error_o); end
    reset = 1'b1;
    step();
    monOn = 1'b1;
  endtask

  task automatic test_power_down();
    clear_rec();
    load(5'b00111);
    wait_idle(60, "pdown");
    total++; if (riseIso[3] != loadCyc + 1) begin bad++; $display("FAIL pdown_iso3_time: got %0d want %0d", riseIso[3], loadCyc + 1); end
    total++; if (fallEn[3] - riseIso[3] != SLEEP_DLY) begin bad++; $display("FAIL pdown_sleep3: got %0d want %0d", fallEn[3] - riseIso[3], SLEEP_DLY); end
    total++; if (fallEn[4] - riseIso[4] != SLEEP_DLY) begin bad++; $display("FAIL pdown_sleep4: got %0d want %0d", fallEn[4] - riseIso[4], SLEEP_DLY); end
    total++; if (riseIso[4] <= fallEn[3]) begin bad++; $display("FAIL pdown_order: lane4 iso at %0d, want after lane3 off at %0d", riseIso[4], fallEn[3]); end
    total++; if (bus.laneActive_o !== 5'b00111) begin bad++; $display("FAIL pdown_active: got %b want 00111", bus.laneActive_o); end
    total++; if (bus.powerEn_o !== 5'b00111) begin bad++; $display("FAIL pdown_en: got %b want 00111", bus.powerEn_o); end
    total++; if (bus.isolate_o !== 5'b11000) begin bad++; $display("FAIL pdown_iso: got %b want 11000", bus.isolate_o); end
    total++; if (doneCnt != 1) begin bad++; $display("FAIL pdown_done: got %0d pulses want 1", doneCnt); end
    total++; if (bus.error_o !== 1'b0) begin bad++; $display("FAIL pdown_error: got %b want 0", bus.error_o); end
  endtask

  task automatic test_power_up();
    ackDly = 3;
    clear_rec();
    load(5'b11111);
    wait_idle(120, "pup");
    // Two synchroniser flops plus the FSM sampling edge, then WAKE_DLY settle cycles.
    total++; if (fallIso[3] != pgRise[3] + 3 + WAKE_DLY) begin bad++; $display("FAIL pup_settle3: iso off %0d want %0d", fallIso[3], pgRise[3] + 3 + WAKE_DLY); end
    total++; if (fallIso[4] != pgRise[4] + 3 + WAKE_DLY) begin bad++; $display("FAIL pup_settle4: iso off %0d want %0d", fallIso[4], pgRise[4] + 3 + WAKE_DLY); end
    total++; if (riseEn[4] <= fallIso[3]) begin bad++; $display("FAIL pup_order: lane4 en at %0d, want after lane3 done at %0d", riseEn[4], fallIso[3]); end
    total++; if (bus.laneActive_o !== 5'b11111) begin bad++; $display("FAIL pup_active: got %b want 11111", bus.laneActive_o); end
    total++; if (bus.isolate_o !== 5'b00000) begin bad++; $display("FAIL pup_iso: got %b want 00000", bus.isolate_o); end
    total++; if (doneCnt != 1) begin bad++; $display("FAIL pup_done: got %0d pulses want 1", doneCnt); end
  endtask

  task automatic test_always_on();
    clear_rec();
    load(5'b00000);
    wait_idle(60, "aon");
    total++; if (bus.laneActive_o !== 5'b00111) begin bad++; $display("FAIL aon_active: got %b want 00111", bus.laneActive_o); end
    total++; if (bus.powerEn_o !== 5'b00111) begin bad++; $display("FAIL aon_en: got %b want 00111", bus.powerEn_o); end
    clear_rec();
    load(5'b00101);
    wait_idle(10, "noop");
    total++; if (lastDone != loadCyc + 1) begin bad++; $display("FAIL noop_done_time: got %0d want %0d", lastDone, loadCyc + 1); end
    total++; if (doneCnt != 1 || touchQ.size() != 0) begin bad++; $display("FAIL noop_quiet: done=%0d touched=%0d want 1 and 0", doneCnt, touchQ.size()); end
  endtask

  task automatic test_timeout();
    int d;
    dead = 5'b01000;
    clear_rec();
    load(5'b01111);
    wait_idle(100, "tmo");
    d = fallEn[3] - riseEn[3];
    total++; if (d < ACK_TIMEOUT + 1 || d > ACK_TIMEOUT + 2) begin bad++; $display("FAIL tmo_duration: en high %0d cycles want %0d..%0d", d, ACK_TIMEOUT + 1, ACK_TIMEOUT + 2); end
    total++; if (bus.error_o !== 1'b1) begin bad++; $display("FAIL tmo_error: got %b want 1", bus.error_o); end
    total++; if (errRise != fallEn[3]) begin bad++; $display("FAIL tmo_error_time: got %0d want %0d", errRise, fallEn[3]); end
    total++; if (bus.powerEn_o !== 5'b00111) begin bad++; $display("FAIL tmo_en: got %b want 00111", bus.powerEn_o); end
    total++; if (bus.laneActive_o !== 5'b00111) begin bad++; $display("FAIL tmo_active: got %b want 00111", bus.laneActive_o); end
    total++; if (bus.isolate_o !== 5'b11000) begin bad++; $display("FAIL tmo_iso: got %b want 11000", bus.isolate_o); end
    total++; if (doneCnt != 1) begin bad++; $display("FAIL tmo_done: got %0d pulses want 1", doneCnt); end
  endtask

  task automatic test_pending();
    dead = '0;
    clear_rec();
    load(5'b11111);
    total++; if (bus.error_o !== 1'b0) begin bad++; $display("FAIL pend_error_clear: got %b want 0", bus.error_o); end
    step(); step();
    load(5'b00111);
    step();
    load(5'b01111);
    wait_idle(250, "pend");
    total++; if (doneCnt != 2) begin bad++; $display("FAIL pend_done: got %0d pulses want 2", doneCnt); end
    total++; if (firstDoneAct !== 5'b11111) begin bad++; $display("FAIL pend_first: got %b want 11111", firstDoneAct); end
    total++; if (bus.laneActive_o !== 5'b01111) begin bad++; $display("FAIL pend_active: got %b want 01111", bus.laneActive_o); end
    total++; if (bus.isolate_o !== 5'b10000) begin bad++; $display("FAIL pend_iso: got %b want 10000", bus.isolate_o); end
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  sawBusy;
    dead = 5'b10000;
    clear_rec();
    load(5'b11111);
    n = 0;
    while (riseEn[4] < 0 && n < 40) begin step(); n++; end
    total++; if (riseEn[4] < 0) begin bad++; $display("FAIL rmid_start: lane4 never enabled within 40 cycles"); end
    step();
    load(5'b00000);
    step(); step();
    #2 reset = 1'b0;
    monOn = 1'b0;
    #1;
    total++; if (bus.powerEn_o !== 5'b11111) begin bad++; $display("FAIL rmid_en: got %b want 11111", bus.powerEn_o); end
    total++; if (bus.laneActive_o !== 5'b11111) begin bad++; $display("FAIL rmid_active: got %b want 11111", bus.laneActive_o); end
    total++; if (bus.isolate_o !== 5'b00000) begin bad++; $display("FAIL rmid_iso: got %b want 00000", bus.isolate_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy_o); end
    step();
    reset = 1'b1;
    dead = '0;
    clear_rec();
    monOn = 1'b1;
    sawBusy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy_o !== 1'b0) sawBusy = 1'b1;
    end
    total++; if (sawBusy || doneCnt != 0) begin bad++; $display("FAIL rmid_pending_lost: busy_seen=%b done=%0d want 0 and 0", sawBusy, doneCnt); end
    total++; if (bus.laneActive_o !== 5'b11111) begin bad++; $display("FAIL rmid_after: got %b want 11111", bus.laneActive_o); end
  endtask

  task automatic test_random();
    logic [4:0] t, tgt, downs, ups, expActive;
    logic       expErr;
    int         expQ[$];
    bit         ordOk;
    modelActive = 5'b11111;
    for (int it = 0; it < 25; it++) begin
      t      = 5'($urandom);
      dead   = 5'($urandom & $urandom) & ~AO;
      ackDly = $urandom_range(1, 6);
      tgt    = t | AO;
      downs  = modelActive & ~tgt;
      ups    = ~modelActive & tgt;
      expActive = (modelActive & tgt) | (ups & ~dead);
      expErr    = |(ups & dead);
      expQ.delete();
      for (int i = 0; i < 5; i++) if (downs[i]) expQ.push_back(i);
      for (int i = 0; i < 5; i++) if (ups[i]) expQ.push_back(i);
      clear_rec();
      load(t);
      wait_idle(300, "rand");
      total++; if (bus.laneActive_o !== expActive) begin bad++; $display("FAIL rand_active it=%0d: got %b want %b", it, bus.laneActive_o, expActive); end
      total++; if (bus.powerEn_o !== expActive) begin bad++; $display("FAIL rand_en it=%0d: got %b want %b", it, bus.powerEn_o, expActive); end
      total++; if (bus.isolate_o !== ~expActive) begin bad++; $display("FAIL rand_iso it=%0d: got %b want %b", it, bus.isolate_o, ~expActive); end
      total++; if (bus.error_o !== expErr) begin bad++; $display("FAIL rand_error it=%0d: got %b want %b", it, bus.error_o, expErr); end
      total++; if (doneCnt != 1) begin bad++; $display("FAIL rand_done it=%0d: got %0d pulses want 1", it, doneCnt); end
      ordOk = (touchQ.size() == expQ.size());
      if (ordOk) for (int j = 0; j < expQ.size(); j++) if (touchQ[j] != expQ[j]) ordOk = 1'b0;
      total++; if (!ordOk) begin bad++; $display("FAIL rand_order it=%0d: got %p want %p", it, touchQ, expQ); end
      modelActive = expActive;
    end
  endtask

  initial begin
    bus.targetMask_i    = '0;
    bus.loadNewConfig_i = 1'b0;
    bus.powerGood_i     = pg;
    for (int i = 0; i < 5; i++) onCnt[i] = 100;
    clear_rec();
    test_reset();
    test_power_down();
    test_power_up();
    test_always_on();
    test_timeout();
    test_pending();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_power_sequencer.md
Name: lane_power_sequencer

Overview:
- Sequences the physical power gates of the execution lanes after the reconfiguration FSM loads a new lane-active configuration.
- Services one lane at a time: power-downs first, then power-ups, each with isolation and settle timing, to bound inrush current.
- Sits between the power-manager lane-active outputs and the per-lane header switches.
- Reports busy/done back to reconfiguration control.

Parameters:
- NUM_LANES, 5: number of gated lanes.
- ALWAYS_ON, 5'b00111: lanes that are never gated; their target bits are forced to 1.
- SLEEP_DLY, 2: cycles isolation is held before power is removed.
- WAKE_DLY, 4: settle cycles after power-good before isolation is released.
- ACK_TIMEOUT, 15: maximum cycles to wait for power-good.
- CNT_W, 4: width of the delay counter; must hold max(SLEEP_DLY, WAKE_DLY, ACK_TIMEOUT).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- targetMask_i  in  NUM_LANES  requested lane-active mask.
- loadNewConfig_i  in  1  single-cycle pulse; sample targetMask_i.
- powerGood_i  in  NUM_LANES  per-lane power-good from the gate cells; asynchronous to the FSM, so it is double-flopped internally.
- powerEn_o  out  NUM_LANES  per-lane header enable.
- isolate_o  out  NUM_LANES  per-lane output isolation clamp.
- laneActive_o  out  NUM_LANES  lanes currently usable by the pipeline.
- busy_o  out  1  sequencing is in progress.
- done_o  out  1  one-cycle pulse when a request completes.
- error_o  out  1  sticky power-good timeout flag.

Behaviour:
- Reset values (reset low):
  - powerEn_o, laneActive_o = all 1; isolate_o = 0.
  - busy_o, done_o, error_o = 0; pending flag = 0; FSM = IDLE.
- Effective target = targetMask_i | ALWAYS_ON, registered on a loadNewConfig_i pulse.
  - If busy: the target goes into a one-deep pending register. A later pulse overwrites it.
- Victim selection:
  - offMask = laneActive_o & ~target.
  - onMask = ~laneActive_o & target.
  - Always pick the lowest-index set bit: offMask first, then onMask.
- FSM states:
  - IDLE: if a new or pending target exists, go to SELECT.
  - SELECT: pick the next lane.
    - offMask lane → ISO_ON.
    - onMask lane → PWR_ON.
    - Neither → DONE.
  - ISO_ON: drive isolate_o[l] = 1 and laneActive_o[l] = 0 in the same cycle as entry. Wait SLEEP_DLY cycles → PWR_OFF.
  - PWR_OFF: drive powerEn_o[l] = 0 (isolation stays asserted). Takes 1 cycle → SELECT.
  - PWR_ON: drive powerEn_o[l] = 1, clear the counter → WAIT_ACK.
  - WAIT_ACK:
    - If the synchronised powerGood[l] = 1 → SETTLE.
    - If the counter reaches ACK_TIMEOUT → set error_o, drive powerEn_o[l] = 0, keep the lane isolated and inactive → SELECT.
  - SETTLE: wait WAKE_DLY cycles → ISO_OFF.
  - ISO_OFF: drive isolate_o[l] = 0 and laneActive_o[l] = 1 → SELECT.
  - DONE: pulse done_o for 1 cycle.
    - If pending is set, move it to target, clear pending → SELECT.
    - Otherwise → IDLE.
- busy_o = 1 in every state except IDLE.
  - busy_o rises on the cycle after the load pulse. done_o is asserted on the cycle busy_o falls.
- A timed-out lane is retried only by a later request. Because it stays inactive, it reappears in onMask.
- error_o clears on the next accepted loadNewConfig_i.
- A load where the target equals current laneActive_o still passes through SELECT → DONE, giving a done pulse 2 cycles after the load.
- powerGood_i dropping for a lane in laneActive_o while IDLE is ignored; the sequencer does not monitor live lanes.
- Reset mid-sequence: all outputs return immediately to reset values (all lanes on). The pending request is lost.
- The counter saturates and never wraps.
- At most one lane changes powerEn_o or isolate_o per cycle.

Decomposition:
- Shared package (power_pkg):
  - sequencer state enum.
  - ALWAYS_ON default.
  - a lowest-set-bit priority-encode function.
- Sub-module lane_sync2: 2-flop synchroniser per powerGood_i bit, reset to 0.

Test Plan:
- Reset then target 5'b00111 → lanes 3 then 4 power down.
  - Per lane: isolate_o set, 2 cycles later powerEn_o clear.
  - Final laneActive_o = 00111; done_o pulses once; error_o = 0.
- From 00111, target 11111 with powerGood returned 3 cycles after powerEn.
  - Lane 3 completes before lane 4 starts.
  - Each lane's isolate_o drops 4 cycles after synchronised power-good.
  - laneActive_o = 11111.
- Target 00000 → ALWAYS_ON forces 00111; lanes 0–2 are never touched.
- From 00111, target 01111 with powerGood[3] held low → after 15 cycles error_o = 1, powerEn_o[3] = 0, laneActive_o = 00111, done_o pulses.
- While busy with 11111, pulse 00111 then 01111 → only 01111 is serviced after the first done. Two done pulses in total; final mask = 01111.
- Assert reset mid-WAIT_ACK → all outputs revert within the same cycle: powerEn_o = 11111, laneActive_o = 11111, isolate_o = 0, busy_o = 0.
